// File: rtl/alu_issue_stage.sv
// alu_issue_stage: register stage feeding the 32-bit ALU.
// Decodes ALUOp/funct into the ALU op code, resolves EX/MEM and MEM/WB
// forwarding for both operands, selects the sign-extended immediate for B,
// and holds the result under a valid/ready handshake.
module alu_issue_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_aluop,
    input  logic [5:0]       in_funct,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [31:0]      in_rs_val,
    input  logic [31:0]      in_rt_val,
    input  logic [15:0]      in_imm,
    input  logic             in_alusrc,
    input  logic [4:0]       in_rd,
    input  logic             in_regwrite,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_rd,
    input  logic [31:0]      mem_val,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      wb_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic [3:0]       out_op,
    output logic [4:0]       out_rd,
    output logic             out_regwrite,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    // Everything the ALU sees for one instruction, held as one register.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        regwrite;
        logic        illegal;
    } issue_t;

    issue_t           cur;
    issue_t           nxt;
    logic             vld;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic [3:0]       dec_op;
    logic             dec_illegal;
    logic [31:0]      fwd_rs;
    logic [31:0]      fwd_rt;

    // MEM wins over WB; register 0 is hardwired and never forwarded.
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf_val,
                                        input logic m_we, input logic [4:0] m_rd, input logic [31:0] m_val,
                                        input logic w_we, input logic [4:0] w_rd, input logic [31:0] w_val);
        if (m_we && m_rd != 5'd0 && m_rd == src)
            return m_val;
        else if (w_we && w_rd != 5'd0 && w_rd == src)
            return w_val;
        else
            return rf_val;
    endfunction

    // The stage can take a new instruction when empty or when the current one leaves.
    assign in_ready = !vld || out_ready;
    assign accept   = in_valid && in_ready;

    // ALUOp/funct to ALU op code; anything unrecognised decodes to 1111 and is flagged.
    always_comb begin
        dec_op      = 4'b1111;
        dec_illegal = 1'b1;
        case (in_aluop)
            2'b00: begin dec_op = 4'b0010; dec_illegal = 1'b0; end
            2'b01: begin dec_op = 4'b0110; dec_illegal = 1'b0; end
            2'b10: begin
                case (in_funct)
                    6'b100000: begin dec_op = 4'b0010; dec_illegal = 1'b0; end
                    6'b100010: begin dec_op = 4'b0110; dec_illegal = 1'b0; end
                    6'b100100: begin dec_op = 4'b0000; dec_illegal = 1'b0; end
                    6'b100101: begin dec_op = 4'b0001; dec_illegal = 1'b0; end
                    6'b101010: begin dec_op = 4'b0111; dec_illegal = 1'b0; end
                    6'b100111: begin dec_op = 4'b1100; dec_illegal = 1'b0; end
                    default:   begin dec_op = 4'b1111; dec_illegal = 1'b1; end
                endcase
            end
            default: begin dec_op = 4'b1111; dec_illegal = 1'b1; end
        endcase
    end

    // Operand resolution and assembly of the value loaded on accept.
    always_comb begin
        fwd_rs       = fwd(in_rs, in_rs_val, mem_regwrite, mem_rd, mem_val, wb_regwrite, wb_rd, wb_val);
        fwd_rt       = fwd(in_rt, in_rt_val, mem_regwrite, mem_rd, mem_val, wb_regwrite, wb_rd, wb_val);
        nxt          = '0;
        nxt.a        = fwd_rs;
        nxt.b        = in_alusrc ? {{16{in_imm[15]}}, in_imm} : fwd_rt;
        nxt.op       = dec_op;
        nxt.rd       = in_rd;
        nxt.regwrite = in_regwrite && !dec_illegal;
        nxt.illegal  = dec_illegal;
    end

    // Output register and illegal counter; flush drops both the held and the incoming instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            cur <= '0;
            cnt <= '0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (accept) begin
            vld <= 1'b1;
            cur <= nxt;
            if (nxt.illegal && cnt != {CNT_W{1'b1}})
                cnt <= cnt + CNT_W'(1);
        end else if (out_ready) begin
            vld <= 1'b0;
        end
    end

    assign out_valid    = vld;
    assign out_a        = cur.a;
    assign out_b        = cur.b;
    assign out_op       = cur.op;
    assign out_rd       = cur.rd;
    assign out_regwrite = cur.regwrite;
    assign out_illegal  = cur.illegal;
    assign illegal_cnt  = cnt;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Register stage directly upstream of the 32-bit ALU. Accepts one decoded instruction per cycle over a valid/ready handshake. Translates ALUOp/funct into the ALU's 4-bit operation code, resolves forwarding for both operands and selects the immediate. Presents registered A, B and Op to the ALU together with destination metadata.

## Interface
Parameters:
- `CNT_W`, 8, width of the saturating illegal-opcode counter

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  discard held and incoming instruction
- `in_valid`  in  1  upstream instruction valid
- `in_ready`  out  1  stage can accept this cycle
- `in_aluop`  in  2  00 add, 01 sub, 10 R-type (use funct), 11 reserved
- `in_funct`  in  6  R-type funct field
- `in_rs`, `in_rt`  in  5 each  source register numbers
- `in_rs_val`, `in_rt_val`  in  32 each  register-file read data
- `in_imm`  in  16  immediate
- `in_alusrc`  in  1  1 = B is sign-extended imm
- `in_rd`  in  5  destination register
- `in_regwrite`  in  1  instruction writes rd
- `mem_regwrite`, `mem_rd`, `mem_val`  in  1/5/32  EX/MEM forwarding source
- `wb_regwrite`, `wb_rd`, `wb_val`  in  1/5/32  MEM/WB forwarding source
- `out_valid`  out  1  registered outputs hold a valid instruction
- `out_ready`  in  1  ALU/downstream consumes this cycle
- `out_a`, `out_b`  out  32 each  ALU operands
- `out_op`  out  4  ALU operation code
- `out_rd`  out  5  destination register
- `out_regwrite`  out  1  write enable; forced 0 when illegal
- `out_illegal`  out  1  instruction did not decode
- `illegal_cnt`  out  CNT_W  saturating count of accepted illegal instructions

## Operation
- Decode of `in_aluop`:
  - 00 gives Op 0010.
  - 01 gives Op 0110.
  - 10 with funct 100000 gives 0010, 100010 gives 0110, 100100 gives 0000, 100101 gives 0001, 101010 gives 0111, 100111 gives 1100.
  - Any other funct, or aluop 11, is illegal: Op 1111, `out_illegal`=1, `out_regwrite`=0.
- Forwarding of A, evaluated on `in_rs`:
  - If `mem_regwrite` and `mem_rd`!=0 and `mem_rd`==`in_rs`, A = `mem_val`.
  - Else if the same condition holds for `wb_*`, A = `wb_val`.
  - Else A = `in_rs_val`.
  - MEM has priority over WB. Register 0 is never forwarded.
- Forwarding of B: same rule on `in_rt`, giving the forwarded rt.
- B source: `out_b` = `{{16{in_imm[15]}}, in_imm}` if `in_alusrc`, else the forwarded rt.
- Capture timing: forwarding and decode are sampled only in the accept cycle. Held outputs are not re-evaluated during a stall.
- Handshake: `in_ready` = !`out_valid` | `out_ready` (combinational).
  - Accept = `in_valid` & `in_ready`.
  - On accept, all out_* registers load and `out_valid`←1.
  - Else, if `out_ready`, `out_valid`←0.
  - Else hold all outputs.
- Flush: `out_valid`←0 next edge, regardless of in/out handshake. An instruction presented in the flush cycle is dropped: no load, no count. Data registers may hold stale values.
- `illegal_cnt`: increments on each accepted illegal instruction (flush not asserted). Saturates at all-ones.
- Reset (synchronous, `rst`=1 at an edge): `out_valid`=0, `out_a`=0, `out_b`=0, `out_op`=0000, `out_rd`=0, `out_regwrite`=0, `out_illegal`=0, `illegal_cnt`=0. Reset overrides flush and accept. Any in-flight instruction is lost.

## Timing
- Latency: 1 cycle from accept edge to `out_*` valid.
- Throughput: 1 instruction per cycle when `out_ready` is held high.
- Back-pressure: `out_valid`=1 and `out_ready`=0 gives `in_ready`=0. Outputs remain stable until consumed.
- Consume and accept in the same cycle: the new instruction replaces the old one, and `out_valid` stays 1.
- Comb paths: `out_ready` to `in_ready` only. No path from in_* to out_*.

## Test plan
- Reset, then `in_aluop`=10, funct=101010, rs_val=0xFFFFFFFF, rt_val=1, alusrc=0, no forwarding:
  - Next cycle: `out_valid`=1, `out_op`=0111, `out_a`=0xFFFFFFFF, `out_b`=1.
- `in_rs`=5, `mem_regwrite`=1, `mem_rd`=5, `mem_val`=0xAA, `wb_rd`=5, `wb_val`=0xBB:
  - `out_a`=0xAA.
  - Repeat with `mem_rd`=0: `out_a`=0xBB.
  - With `in_rs`=0 and both rd=0: `out_a`=`in_rs_val`.
- `in_alusrc`=1, `in_imm`=0x8004, aluop=00:
  - `out_b`=0xFFFF8004, `out_op`=0010.
- `out_ready`=0 for 3 cycles while a new `in_valid` is pending:
  - `in_ready`=0 and outputs unchanged.
  - Raise `out_ready`: the new instruction loads the following cycle with no gap.
- Send funct=000000 with aluop=10 and `in_regwrite`=1, 300 times:
  - `out_illegal`=1, `out_op`=1111, `out_regwrite`=0.
  - `illegal_cnt` stops at 255.
- Assert `flush` with `in_valid`=1 while `out_valid`=1:
  - Next cycle `out_valid`=0 and the count is unchanged.
  - Assert `rst` mid-stall: every output returns to its reset value.
